// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the requester-side (fetch and data) and memory-side
// handshake signals of the single-port memory arbiter.
//   slave  : arbiter view (takes requests, drives memory and completions)
//   master : environment view (datapath requesters plus memory model)
interface mem_arbiter_if #(
  parameter int unsigned WIDTH = 16
);
  // Instruction-fetch port
  logic             iReq;
  logic [WIDTH-1:0] iAddr;
  logic [WIDTH-1:0] iRdata;
  logic             iValid;
  // Data (load/store) port
  logic             dMemRd;
  logic             dMemWr;
  logic [WIDTH-1:0] dAddr;
  logic [WIDTH-1:0] dWdata;
  logic [WIDTH-1:0] dRdata;
  logic             dValid;
  // Memory handshake
  logic             memReq;
  logic             memWe;
  logic [WIDTH-1:0] memAddr;
  logic [WIDTH-1:0] memWdata;
  logic [WIDTH-1:0] memRdata;
  logic             memAck;
  // Pipeline stalls
  logic             stallF;
  logic             stallM;

  modport slave (
    input  iReq, iAddr, dMemRd, dMemWr, dAddr, dWdata, memRdata, memAck,
    output iRdata, iValid, dRdata, dValid, memReq, memWe, memAddr, memWdata, stallF, stallM
  );

  modport master (
    output iReq, iAddr, dMemRd, dMemWr, dAddr, dWdata, memRdata, memAck,
    input  iRdata, iValid, dRdata, dValid, memReq, memWe, memAddr, memWdata, stallF, stallM
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction fetches and data accesses onto one
// variable-latency memory port. Data has priority over fetch. A port whose
// completion pulse is high this cycle is not re-arbitrated in that cycle.
// Optional build macro MEM_ARB_STARVE_GUARD_EN: after STARVE_LIMIT consecutive
// data grants with a fetch waiting, the next IDLE decision goes to the fetch.
// STARVE_LIMIT must be >= 1 when the guard is built.
module mem_arbiter #(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]       r_state;
  logic             r_mem_req;
  logic             r_mem_we;
  logic [WIDTH-1:0] r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;
  logic [WIDTH-1:0] r_i_rdata;
  logic [WIDTH-1:0] r_d_rdata;
  logic             r_i_valid;
  logic             r_d_valid;

  logic w_d_req;
  logic w_d_pend;
  logic w_i_pend;
  logic w_starve_hit;
  logic w_grant_d;
  logic w_grant_i;

  // Pending requests exclude the one completing this cycle.
  assign w_d_req   = bus.dMemRd | bus.dMemWr;
  assign w_d_pend  = w_d_req & ~r_d_valid;
  assign w_i_pend  = bus.iReq & ~r_i_valid;
  assign w_grant_d = (r_state == IDLE) & w_d_pend & ~(w_starve_hit & w_i_pend);
  assign w_grant_i = (r_state == IDLE) & w_i_pend & ~w_grant_d;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_starve_hit = (r_starve_cnt == CNT_W'(STARVE_LIMIT));

  // Count data grants made while a fetch waits; saturate at the limit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (!bus.iReq || w_grant_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d && !w_starve_hit) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_starve_hit = 1'b0;
`endif

  // Arbitration FSM: latch the granted request, hold it until memAck.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_valid   <= 1'b0;
      r_d_valid   <= 1'b0;
    end else begin
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_d) begin
            r_mem_req   <= 1'b1;
            // Read and write together is treated as a load.
            r_mem_we    <= bus.dMemWr & ~bus.dMemRd;
            r_mem_addr  <= bus.dAddr;
            r_mem_wdata <= bus.dWdata;
            r_state     <= BUSY_D;
          end else if (w_grant_i) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= bus.iAddr;
            r_state    <= BUSY_I;
          end
        end
        BUSY_I: begin
          if (bus.memAck) begin
            r_mem_req <= 1'b0;
            r_i_rdata <= bus.memRdata;
            r_i_valid <= 1'b1;
            r_state   <= IDLE;
          end
        end
        BUSY_D: begin
          if (bus.memAck) begin
            r_mem_req <= 1'b0;
            if (!r_mem_we) begin
              r_d_rdata <= bus.memRdata;
            end
            r_d_valid <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.memReq   = r_mem_req;
  assign bus.memWe    = r_mem_we;
  assign bus.memAddr  = r_mem_addr;
  assign bus.memWdata = r_mem_wdata;
  assign bus.iRdata   = r_i_rdata;
  assign bus.iValid   = r_i_valid;
  assign bus.dRdata   = r_d_rdata;
  assign bus.dValid   = r_d_valid;
  assign bus.stallF   = bus.iReq & ~r_i_valid;
  assign bus.stallM   = w_d_req & ~r_d_valid;

endmodule
